// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - round-robin arbiter and single-byte SPI SRAM sequencer for fetch/data ports
module spi_mem_arbiter #(
    parameter int         CPU_ADDR_W = 8,
    parameter int         SPI_ADDR_W = 16,
    parameter logic [7:0] CMD_READ   = 8'h03,
    parameter logic [7:0] CMD_WRITE  = 8'h02
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [CPU_ADDR_W-1:0] f_addr,
    output logic                  f_ack,
    output logic [7:0]            f_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [CPU_ADDR_W-1:0] d_addr,
    input  logic [7:0]            d_wdata,
    output logic                  d_ack,
    output logic [7:0]            d_rdata,
    output logic                  busy,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int SR_W  = 16 + SPI_ADDR_W;
    localparam int CNT_W = $clog2(2 * SR_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SR_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_grant;
    logic              grant;
    logic              we_q;
    logic [SR_W-1:0]   sr;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        rx;

    logic                  sel;
    logic                  sel_we;
    logic [SPI_ADDR_W-1:0] addr_ext;
    logic [SR_W-1:0]       load_word;

    // Port 1 is chosen when it alone requests, or on a tie when port 0 was served last.
    always_comb begin
        sel = 1'b0;
        if (f_req && d_req) begin
            sel = ~last_grant;
        end else if (d_req) begin
            sel = 1'b1;
        end
        sel_we   = sel & d_we;
        addr_ext = '0;
        addr_ext[CPU_ADDR_W-1:0] = sel ? d_addr : f_addr;
        load_word = {sel_we ? CMD_WRITE : CMD_READ, addr_ext, sel_we ? d_wdata : 8'h00};
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (f_req || d_req) next_state = CS_SETUP;
            CS_SETUP: next_state = SHIFT;
            SHIFT:    if (cnt == CNT_LAST) next_state = CS_HOLD;
            CS_HOLD:  next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            we_q       <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            rx         <= '0;
            f_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_req || d_req) begin
                        grant <= sel;
                        we_q  <= sel_we;
                        sr    <= load_word;
                    end
                end
                CS_SETUP: cnt <= '0;
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    // Even count is the LO phase: its closing edge raises sclk and samples miso.
                    if (!cnt[0]) begin
                        rx <= {rx[6:0], spi_miso};
                    end else begin
                        sr <= {sr[SR_W-2:0], 1'b0};
                    end
                end
                CS_HOLD: begin
                    if (!grant) begin
                        f_rdata <= rx;
                    end else if (!we_q) begin
                        d_rdata <= rx;
                    end
                end
                DONE: last_grant <= grant;
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign spi_cs_n = !((state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD));
    assign spi_sclk = (state == SHIFT) && cnt[0];
    assign spi_mosi = ((state == CS_SETUP) || (state == SHIFT)) ? sr[SR_W-1] : 1'b0;
    assign f_ack    = (state == DONE) && !grant;
    assign d_ack    = (state == DONE) && grant;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - directed bench for spi_mem_arbiter with behavioural SPI SRAM
module tb_spi_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       f_req = 1'b0;
    logic [7:0] f_addr = '0;
    logic       f_ack;
    logic [7:0] f_rdata;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [7:0] d_addr = '0;
    logic [7:0] d_wdata = '0;
    logic       d_ack;
    logic [7:0] d_rdata;
    logic       busy;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso = 1'b0;

    int checks = 0;
    int failures = 0;

    spi_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Behavioural 23LC512-style SRAM, byte mode, SPI mode 0
    logic [7:0]  mem [0:65535];
    logic [31:0] mon = '0;
    logic [31:0] last_mon = '0;
    logic [7:0]  rd_byte = '0;
    int          edges = 0;
    int          last_edges = 0;
    int          bad_sclk = 0;

    always @(negedge spi_cs_n) begin
        edges = 0;
        mon = '0;
        spi_miso = 1'b0;
    end

    always @(posedge spi_cs_n) begin
        last_mon = mon;
        last_edges = edges;
    end

    always @(posedge spi_sclk) begin
        if (spi_cs_n) begin
            bad_sclk++;
        end else begin
            mon = {mon[30:0], spi_mosi};
            edges++;
            if (edges == 24) rd_byte = mem[mon[15:0]];
            if (edges == 32 && mon[31:24] == 8'h02) mem[mon[23:8]] = mon[7:0];
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n && edges >= 24 && edges < 32) begin
            int idx;
            idx = 31 - edges;
            spi_miso = rd_byte[idx];
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output int k, output bit which);
        k = -1;
        which = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (f_ack || d_ack) begin
                k = i;
                which = d_ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk); #1;
        checks++;
        if ({spi_cs_n, spi_sclk, spi_mosi, f_ack, d_ack, busy} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got %b exp 100000", {spi_cs_n, spi_sclk, spi_mosi, f_ack, d_ack, busy});
        end
        checks++;
        if ({f_rdata, d_rdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rdata got %h exp 0000", {f_rdata, d_rdata});
        end
    endtask

    task automatic test_fetch_read();
        int k; bit w;
        mem[16'h0010] = 8'hA5;
        @(negedge clk);
        f_addr = 8'h10; f_req = 1'b1;
        wait_ack(k, w);
        f_req = 1'b0;
        checks++;
        if (k !== 67 || w !== 1'b0) begin
            failures++;
            $display("FAIL fetch_latency got k=%0d port=%0d exp k=67 port=0", k, w);
        end
        checks++;
        if (f_rdata !== 8'hA5) begin
            failures++;
            $display("FAIL fetch_rdata got %h exp a5", f_rdata);
        end
        checks++;
        if (last_mon !== 32'h0300_1000 || last_edges !== 32) begin
            failures++;
            $display("FAIL fetch_stream got %h/%0d exp 03001000/32", last_mon, last_edges);
        end
        @(posedge clk); #1;
        checks++;
        if (f_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack_pulse got ack=%b busy=%b exp 0 0", f_ack, busy);
        end
    endtask

    task automatic test_data_write();
        int k; bit w;
        @(negedge clk);
        d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C; d_req = 1'b1;
        wait_ack(k, w);
        d_req = 1'b0;
        checks++;
        if (k !== 67 || w !== 1'b1) begin
            failures++;
            $display("FAIL write_latency got k=%0d port=%0d exp k=67 port=1", k, w);
        end
        checks++;
        if (last_mon !== 32'h0200_203C) begin
            failures++;
            $display("FAIL write_stream got %h exp 0200203c", last_mon);
        end
        checks++;
        if (mem[16'h0020] !== 8'h3C || d_rdata !== 8'h00) begin
            failures++;
            $display("FAIL write_mem got mem=%h d_rdata=%h exp 3c 00", mem[16'h0020], d_rdata);
        end
        d_we = 1'b0;
    endtask

    task automatic test_tie_after_reset();
        int k; int gap; bit w;
        mem[16'h0030] = 8'h11;
        mem[16'h0031] = 8'h22;
        apply_reset();
        @(negedge clk);
        f_addr = 8'h30; d_addr = 8'h31; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        wait_ack(k, w);
        f_req = 1'b0;
        checks++;
        if (k !== 67 || w !== 1'b0 || f_rdata !== 8'h11) begin
            failures++;
            $display("FAIL tie_first got k=%0d port=%0d rdata=%h exp 67 0 11", k, w, f_rdata);
        end
        gap = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (!spi_cs_n) begin
                gap = i;
                break;
            end
        end
        checks++;
        if (gap !== 2) begin
            failures++;
            $display("FAIL tie_cs_gap got %0d exp 2", gap);
        end
        wait_ack(k, w);
        d_req = 1'b0;
        checks++;
        if (k < 0 || w !== 1'b1 || d_rdata !== 8'h22) begin
            failures++;
            $display("FAIL tie_second got k=%0d port=%0d rdata=%h exp port=1 22", k, w, d_rdata);
        end
    endtask

    task automatic test_round_robin();
        int k; bit w;
        bit exp_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        mem[16'h0040] = 8'h44;
        mem[16'h0041] = 8'h55;
        @(negedge clk);
        f_addr = 8'h40; d_addr = 8'h41; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ack(k, w);
            if (n == 3) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            checks++;
            if (k < 0 || w !== exp_seq[n]) begin
                failures++;
                $display("FAIL rr_grant%0d got k=%0d port=%0d exp port=%0d", n, k, w, exp_seq[n]);
            end
        end
        checks++;
        if (f_rdata !== 8'h44 || d_rdata !== 8'h55) begin
            failures++;
            $display("FAIL rr_rdata got %h %h exp 44 55", f_rdata, d_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int k; bit w; int acks;
        mem[16'h0050] = 8'h77;
        @(negedge clk);
        f_addr = 8'h50; f_req = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_cs_n, spi_sclk, busy} !== 3'b100) begin
            failures++;
            $display("FAIL midreset_outputs got %b exp 100", {spi_cs_n, spi_sclk, busy});
        end
        f_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (f_ack || d_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL midreset_ack got %0d exp 0", acks);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f_req = 1'b1;
        wait_ack(k, w);
        f_req = 1'b0;
        checks++;
        if (k !== 67 || w !== 1'b0 || f_rdata !== 8'h77 || last_edges !== 32) begin
            failures++;
            $display("FAIL midreset_recover got k=%0d port=%0d rdata=%h edges=%0d exp 67 0 77 32", k, w, f_rdata, last_edges);
        end
    endtask

    task automatic test_back_to_back();
        int k; bit w;
        mem[16'h0000] = 8'h5A;
        mem[16'h00FF] = 8'hC3;
        @(negedge clk);
        d_addr = 8'h00; d_we = 1'b0; d_req = 1'b1;
        wait_ack(k, w);
        d_req = 1'b0;
        f_addr = 8'hFF; f_req = 1'b1;
        checks++;
        if (w !== 1'b1 || d_rdata !== 8'h5A || last_mon !== 32'h0300_0000 || last_edges !== 32) begin
            failures++;
            $display("FAIL b2b_first got port=%0d rdata=%h mon=%h edges=%0d exp 1 5a 03000000 32", w, d_rdata, last_mon, last_edges);
        end
        wait_ack(k, w);
        f_req = 1'b0;
        checks++;
        if (k !== 68 || w !== 1'b0 || f_rdata !== 8'hC3) begin
            failures++;
            $display("FAIL b2b_second got k=%0d port=%0d rdata=%h exp 68 0 c3", k, w, f_rdata);
        end
        checks++;
        if (last_mon !== 32'h0300_FF00 || last_edges !== 32) begin
            failures++;
            $display("FAIL b2b_stream got %h/%0d exp 0300ff00/32", last_mon, last_edges);
        end
        checks++;
        if (bad_sclk !== 0) begin
            failures++;
            $display("FAIL sclk_while_cs_high got %0d exp 0", bad_sclk);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        test_reset();
        test_fetch_read();
        test_data_write();
        test_tie_after_reset();
        test_round_robin();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
